output_reordering: RTL and testbench
====================================

OUTPUT_REORDERING -- requirements
Module: output_reordering

Interface
REQ-001 The block SHALL have the following parameters: none; frame length is fixed at N=1024 points, data width fixed at 32 bits per component.
REQ-002 The block SHALL have the following ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid_in  input  1  input sample strobe, one FFT result per asserted cycle.
- i_data_real  input  32  real part of FFT result, arriving in bit-reversed index order.
- i_data_imag  input  32  imaginary part of FFT result.
- i_ready_out  input  1  downstream ready; transfer occurs when o_valid_out & i_ready_out.
- o_valid_out  output  1  output word valid.
- o_data_real  output  32  real part, natural index order.
- o_data_imag  output  32  imaginary part, natural index order.
- o_sof  output  1  high with output word of natural index 0.
- o_eof  output  1  high with output word of natural index 1023.
- o_overflow  output  1  sticky: an input sample was dropped.

Function
REQ-003 Storage SHALL be two banks (A, B), each 1024 x 64 bits (real+imag), using synchronous-read dual-port RAM with 1-cycle read latency.
REQ-004 Write side: 10-bit wr_cnt and wr_bank bit; on accepted i_valid_in, write to bank wr_bank at address bitrev10(wr_cnt) (bit 0<->9, 1<->8, ...), then wr_cnt increments.
REQ-005 On accepted write with wr_cnt=1023: wr_cnt wraps to 0, full flag of wr_bank sets, wr_bank toggles.
REQ-006 If i_valid_in is high while the full flag of wr_bank is already set, the sample SHALL be dropped, wr_cnt SHALL hold, and o_overflow SHALL set and remain 1 until reset.
REQ-007 Read FSM states: IDLE, STREAM. IDLE->STREAM when full flag of rd_bank is set; STREAM issues sequential addresses rd_cnt=0..1023 from rd_bank.
REQ-008 Output path SHALL be a 2-entry FIFO holding {data, sof, eof}; o_valid_out = FIFO not empty; o_data/o_sof/o_eof = FIFO head.
REQ-009 A read SHALL be issued in a cycle only if in STREAM and (FIFO count + reads in flight - pop this cycle) < 2; data SHALL enter the FIFO on the following edge.
REQ-010 On issue of rd_cnt=1023: full flag of rd_bank clears, rd_bank toggles, rd_cnt wraps to 0; FSM goes to STREAM if the new rd_bank is full, else IDLE (no bubble between back-to-back frames).
REQ-011 Simultaneous full-flag set (writer) and clear (reader) on different banks SHALL both take effect; a bank freed on cycle T SHALL accept writes from cycle T+1.
REQ-012 Latency: with i_ready_out=1, o_valid_out SHALL assert for index 0 exactly 2 cycles after the edge that sets the frame's full flag; throughput 1 word/cycle thereafter.
REQ-013 With i_ready_out=0, FIFO head SHALL hold stable and no word SHALL be lost or duplicated.
REQ-014 o_sof SHALL be 1 only with index 0 and o_eof only with index 1023; both 0 when o_valid_out=0.

Reset
REQ-015 On i_reset=0 (any time, including mid-frame): wr_cnt=0, rd_cnt=0, wr_bank=A, rd_bank=A, both full flags=0, FSM=IDLE, FIFO empty, reads in flight cleared.
REQ-016 Reset outputs: o_valid_out=0, o_sof=0, o_eof=0, o_overflow=0, o_data_real=0, o_data_imag=0; partial frames discarded; RAM contents need not be cleared.

Verification
REQ-017 Single frame: write input j with real=bitrev10(j), imag=~bitrev10(j), i_ready_out=1 -> outputs real 0..1023 ascending, imag bitwise complement, o_sof at 0, o_eof at 1023, first o_valid_out 2 cycles after last write.
REQ-018 Back-to-back: 3 continuous frames, no input gaps -> 3072 contiguous valid outputs, no bubbles, correct order, o_overflow=0.
REQ-019 Backpressure: random i_ready_out (50%) over 2 frames -> every word delivered exactly once, in order, head stable while stalled.
REQ-020 Overflow: i_ready_out=0, write 2 full frames then 5 more samples -> o_overflow=1, wr_cnt=0; after raising ready, both frames output intact.
REQ-021 Reset mid-operation: assert i_reset at input index 500 of frame 2 -> all outputs 0 immediately; next full frame outputs correctly starting with o_sof.

Source files
------------

// File: rtl/output_reordering.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : output_reordering                                          |
// | Description : Reorders 1024-point FFT results from bit-reversed to       |
// |               natural index order through two ping-pong RAM banks and    |
// |               a 2-entry output FIFO with ready/valid handshake.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module output_reordering (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid_in,
    input  logic [31:0] i_data_real,
    input  logic [31:0] i_data_imag,
    input  logic        i_ready_out,
    output logic        o_valid_out,
    output logic [31:0] o_data_real,
    output logic [31:0] o_data_imag,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_overflow
);

    localparam logic [9:0] c_last_idx = 10'd1023;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Write side
    logic [9:0]       r_wr_cnt;
    logic             r_wr_bank;
    logic [1:0]       r_full;
    logic             r_overflow;
    logic [9:0]       w_wr_addr;
    logic             w_wr_accept;
    logic             w_wr_last;
    logic [1:0]       w_full_nxt;

    // Read side
    state_t           r_state;
    logic [9:0]       r_rd_cnt;
    logic             r_rd_bank;
    logic             r_inflight;
    logic             r_inflight_bank;
    logic             r_inflight_sof;
    logic             r_inflight_eof;
    logic [2:0]       w_occ;
    logic             w_issue;
    logic             w_rd_last;
    logic [1:0][63:0] w_bank_q;
    logic [63:0]      w_rd_word;

    // Output FIFO: each entry is {real, imag, sof, eof}
    logic [1:0][65:0] r_fifo;
    logic             r_fifo_wptr;
    logic             r_fifo_rptr;
    logic [1:0]       r_fifo_cnt;
    logic [65:0]      w_head;
    logic             w_push;
    logic             w_pop;

    // Write address is the bit-reversed sample counter.
    always_comb begin
        w_wr_addr = '0;
        for (int k = 0; k < 10; k++) begin
            w_wr_addr[k] = r_wr_cnt[9 - k];
        end
    end

    // A sample is accepted only while the target bank is not waiting to be read.
    assign w_wr_accept = i_valid_in & ~r_full[r_wr_bank];
    assign w_wr_last   = w_wr_accept & (r_wr_cnt == c_last_idx);

    // Next full flags: reader clear and writer set always hit different banks.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // Write counter, bank select, full flags and sticky overflow.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_full     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_accept) begin
                r_wr_cnt <= r_wr_cnt + 10'd1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (i_valid_in && !w_wr_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Slots already committed: stored words plus the word leaving RAM, minus
    // the word handed downstream this cycle. Two slots keep full throughput.
    assign w_occ     = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = (r_state == ST_STREAM) && (w_occ < 3'd2);
    assign w_rd_last = w_issue & (r_rd_cnt == c_last_idx);

    // Read FSM. Entering STREAM on the edge that fills the bank lets the first
    // word reach the FIFO two edges later; on frame end it continues straight
    // into the other bank when that one is (or is becoming) full.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_full_nxt[r_rd_bank]) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_issue) begin
                        r_rd_cnt <= r_rd_cnt + 10'd1;
                        if (r_rd_cnt == c_last_idx) begin
                            r_rd_bank <= ~r_rd_bank;
                            r_state   <= w_full_nxt[~r_rd_bank] ? ST_STREAM : ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag each issued read so its word lands in the FIFO one edge later.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_inflight      <= 1'b0;
            r_inflight_bank <= 1'b0;
            r_inflight_sof  <= 1'b0;
            r_inflight_eof  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_bank <= r_rd_bank;
                r_inflight_sof  <= (r_rd_cnt == 10'd0);
                r_inflight_eof  <= (r_rd_cnt == c_last_idx);
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic c_bank_id = 1'(b);
        logic [63:0] r_mem [0:1023];
        logic [63:0] r_q;

        // Dual-port bank: scattered write, sequential read with registered output.
        always_ff @(posedge i_clk) begin
            if (w_wr_accept && (r_wr_bank == c_bank_id)) begin
                r_mem[w_wr_addr] <= {i_data_real, i_data_imag};
            end
            if (w_issue && (r_rd_bank == c_bank_id)) begin
                r_q <= r_mem[r_rd_cnt];
            end
        end

        assign w_bank_q[b] = r_q;
    end

    assign w_rd_word = w_bank_q[r_inflight_bank];
    assign w_push    = r_inflight;
    assign w_pop     = o_valid_out & i_ready_out;

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fifo_wptr <= 1'b0;
            r_fifo_rptr <= 1'b0;
            r_fifo_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wptr <= ~r_fifo_wptr;
            end
            if (w_pop) begin
                r_fifo_rptr <= ~r_fifo_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_fifo_wptr] <= {w_rd_word, r_inflight_sof, r_inflight_eof};
        end
    end

    assign w_head      = r_fifo[r_fifo_rptr];
    assign o_valid_out = (r_fifo_cnt != 2'd0);
    assign o_data_real = o_valid_out ? w_head[65:34] : 32'd0;
    assign o_data_imag = o_valid_out ? w_head[33:2]  : 32'd0;
    assign o_sof       = o_valid_out & w_head[1];
    assign o_eof       = o_valid_out & w_head[0];
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_output_reordering.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_output_reordering                                       |
// | Description : Self-checking bench for output_reordering. Frames are      |
// |               built in natural order and sent bit-reversed; a queue of   |
// |               natural-order words is the expected output stream.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_output_reordering;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid_in;
    logic [31:0] i_data_real;
    logic [31:0] i_data_imag;
    logic        i_ready_out;
    logic        o_valid_out;
    logic [31:0] o_data_real;
    logic [31:0] o_data_imag;
    logic        o_sof;
    logic        o_eof;
    logic        o_overflow;

    output_reordering dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid_in  (i_valid_in),
        .i_data_real (i_data_real),
        .i_data_imag (i_data_imag),
        .i_ready_out (i_ready_out),
        .o_valid_out (o_valid_out),
        .o_data_real (o_data_real),
        .o_data_imag (o_data_imag),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        bit          sof;
        bit          eof;
    } word_t;

    typedef struct {
        int          idx;
        logic [31:0] re;
        logic [31:0] im;
        bit          sof;
        bit          eof;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    word_t       exp_q[$];
    logic [31:0] nat_re [1024];
    logic [31:0] nat_im [1024];
    logic [31:0] cap_re [1024];
    logic [31:0] cap_im [1024];
    bit          cap_sof [1024];
    bit          cap_eof [1024];
    int          xfer_n = 0;
    int          ready_mode = 0;
    bit          stall_pending = 1'b0;
    logic [65:0] stall_word;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int bitrev10(input int v);
        logic [9:0] a;
        logic [9:0] r;
        a = v[9:0];
        for (int i = 0; i < 10; i++) begin
            r[i] = a[9 - i];
        end
        return int'({22'd0, r});
    endfunction

    // Natural-order frame contents: fixed pattern or random words.
    task automatic fill_frame(input bit rnd);
        for (int k = 0; k < 1024; k++) begin
            if (rnd) begin
                nat_re[k] = $urandom;
                nat_im[k] = $urandom;
            end else begin
                nat_re[k] = 32'(k);
                nat_im[k] = ~32'(k);
            end
        end
    endtask

    // Send input positions 0..stop_at-1 in bit-reversed order; a complete
    // frame adds its natural-order words to the expected stream.
    task automatic send_frame(input int stop_at, input int gap_pct);
        word_t w;
        for (int j = 0; j < stop_at; j++) begin
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                i_valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            i_valid_in  = 1'b1;
            i_data_real = nat_re[bitrev10(j)];
            i_data_imag = nat_im[bitrev10(j)];
            @(posedge clk);
            #1;
        end
        i_valid_in = 1'b0;
        if (stop_at == 1024) begin
            for (int k = 0; k < 1024; k++) begin
                w.re  = nat_re[k];
                w.im  = nat_im[k];
                w.sof = (k == 0);
                w.eof = (k == 1023);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 68'(exp_q.size()), 68'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Downstream ready pattern.
    initial begin : ready_drv
        i_ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       i_ready_out = 1'b1;
                1:       i_ready_out = 1'($urandom_range(0, 1));
                default: i_ready_out = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard, head stability and idle-flag checks.
    initial begin : monitor
        word_t e;
        forever begin
            @(negedge clk);
            if (i_reset !== 1'b1) begin
                stall_pending = 1'b0;
            end else begin
                if (stall_pending) begin
                    check("head_stable",
                          68'({o_valid_out, o_data_real, o_data_imag, o_sof, o_eof}),
                          68'({1'b1, stall_word}));
                end
                stall_pending = 1'b0;
                if (!o_valid_out) begin
                    check("idle_flags", 68'({o_sof, o_eof}), 68'(0));
                end else if (i_ready_out) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h, expected no word at %0t",
                                 {o_data_real, o_data_imag}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word",
                              68'({o_data_real, o_data_imag, o_sof, o_eof}),
                              68'({e.re, e.im, e.sof, e.eof}));
                    end
                    if (xfer_n < 1024) begin
                        cap_re[xfer_n]  = o_data_real;
                        cap_im[xfer_n]  = o_data_imag;
                        cap_sof[xfer_n] = o_sof;
                        cap_eof[xfer_n] = o_eof;
                    end
                    xfer_n++;
                end else begin
                    stall_pending = 1'b1;
                    stall_word    = {o_data_real, o_data_imag, o_sof, o_eof};
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        vec_t tbl [8];
        int   bubbles;
        int   waitc;

        tbl[0] = '{0,    32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[1] = '{1,    32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{2,    32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0};
        tbl[3] = '{511,  32'h0000_01FF, 32'hFFFF_FE00, 1'b0, 1'b0};
        tbl[4] = '{512,  32'h0000_0200, 32'hFFFF_FDFF, 1'b0, 1'b0};
        tbl[5] = '{1000, 32'h0000_03E8, 32'hFFFF_FC17, 1'b0, 1'b0};
        tbl[6] = '{1022, 32'h0000_03FE, 32'hFFFF_FC01, 1'b0, 1'b0};
        tbl[7] = '{1023, 32'h0000_03FF, 32'hFFFF_FC00, 1'b0, 1'b1};

        i_reset     = 1'b0;
        i_valid_in  = 1'b0;
        i_data_real = '0;
        i_data_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 68'({o_valid_out, o_sof, o_eof, o_overflow}), 68'(0));
        check("rst_data", 68'({o_data_real, o_data_imag}), 68'(0));
        i_reset = 1'b1;
        @(posedge clk);
        #1;

        // Single frame with the index pattern, plus first-word latency.
        fill_frame(1'b0);
        xfer_n = 0;
        send_frame(1024, 0);
        check("lat_edge0", 68'(o_valid_out), 68'(0));
        @(posedge clk);
        #1;
        check("lat_edge1", 68'(o_valid_out), 68'(0));
        @(posedge clk);
        #1;
        check("lat_edge2", 68'({o_valid_out, o_sof}), 68'(2'b11));
        wait_drain("drain_single", 1500);
        check("single_count", 68'(xfer_n), 68'(1024));
        for (int t = 0; t < 8; t++) begin
            check("tbl_word",
                  68'({cap_re[tbl[t].idx], cap_im[tbl[t].idx], cap_sof[tbl[t].idx], cap_eof[tbl[t].idx]}),
                  68'({tbl[t].re, tbl[t].im, tbl[t].sof, tbl[t].eof}));
        end

        // Three back-to-back frames: output must be one unbroken burst.
        xfer_n = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    fill_frame(1'b1);
                    send_frame(1024, 0);
                end
            end
            begin
                waitc = 0;
                while (!o_valid_out && waitc < 3000) begin
                    @(negedge clk);
                    waitc++;
                end
                check("b2b_start", 68'(o_valid_out), 68'(1));
                bubbles = 0;
                repeat (3071) begin
                    @(negedge clk);
                    if (!o_valid_out) bubbles++;
                end
                check("b2b_bubbles", 68'(bubbles), 68'(0));
            end
        join
        wait_drain("drain_b2b", 2000);
        check("b2b_count", 68'(xfer_n), 68'(3072));
        check("b2b_ovf", 68'(o_overflow), 68'(0));

        // Random backpressure and random input gaps over two frames.
        ready_mode = 1;
        xfer_n = 0;
        for (int f = 0; f < 2; f++) begin
            fill_frame(1'b1);
            send_frame(1024, 20);
        end
        wait_drain("drain_bp", 8000);
        check("bp_count", 68'(xfer_n), 68'(2048));
        check("bp_ovf", 68'(o_overflow), 68'(0));
        ready_mode = 0;

        // Overflow: both banks full while stalled, then 5 extra samples.
        ready_mode = 2;
        @(posedge clk);
        #1;
        xfer_n = 0;
        for (int f = 0; f < 2; f++) begin
            fill_frame(1'b1);
            send_frame(1024, 0);
        end
        check("ovf_before", 68'(o_overflow), 68'(0));
        for (int i = 0; i < 5; i++) begin
            i_valid_in  = 1'b1;
            i_data_real = $urandom;
            i_data_imag = $urandom;
            @(posedge clk);
            #1;
        end
        i_valid_in = 1'b0;
        check("ovf_set", 68'(o_overflow), 68'(1));
        ready_mode = 0;
        wait_drain("drain_ovf", 3000);
        check("ovf_count", 68'(xfer_n), 68'(2048));
        xfer_n = 0;
        fill_frame(1'b1);
        send_frame(1024, 0);
        wait_drain("drain_after_ovf", 1500);
        check("after_ovf_count", 68'(xfer_n), 68'(1024));
        check("ovf_sticky", 68'(o_overflow), 68'(1));

        // Asynchronous reset at input index 500 of the second frame.
        fill_frame(1'b1);
        send_frame(1024, 0);
        fill_frame(1'b1);
        send_frame(500, 0);
        check("pre_rst_valid", 68'(o_valid_out), 68'(1));
        #2;
        i_reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 68'({o_valid_out, o_sof, o_eof, o_overflow}), 68'(0));
        check("rst_mid_data", 68'({o_data_real, o_data_imag}), 68'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        xfer_n = 0;
        fill_frame(1'b1);
        send_frame(1024, 0);
        wait_drain("drain_post_rst", 1500);
        check("post_rst_count", 68'(xfer_n), 68'(1024));
        check("post_rst_sof", 68'({cap_sof[0], cap_re[0], cap_im[0]}), 68'({1'b1, nat_re[0], nat_im[0]}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
